// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array output path: default stream
// format, the saturating clamp helper and the accumulator state encoding.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DATA_FRAC  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic signed [63:0] value;
    logic               ovf;
  } sat_res_t;

  // Clamp a wide signed value into a signed range of 'width' bits. The
  // returned value is still 64 bits wide; callers keep the low 'width' bits.
  function automatic sat_res_t sat_clamp(input logic signed [63:0] val,
                                         input int unsigned width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sat_res_t           res;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (val > max_v) begin
      res.value = max_v;
      res.ovf   = 1'b1;
    end else if (val < min_v) begin
      res.value = min_v;
      res.ovf   = 1'b1;
    end else begin
      res.value = val;
      res.ovf   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/psum_accum_if.sv
// Stream bundle between the saturating adder, the partial-sum accumulator
// and its consumer. The slave side is the accumulator itself.
interface psum_accum_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         flush;
  logic                         stall_out;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_sat;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  stall_out, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output stall_out, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums ACC_LEN samples (or fewer on flush) in a
// widened accumulator, saturates the total and holds it in a one-entry
// result register with valid/ready handshake and upstream stall.
module psum_accum
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_FRAC  = DEF_DATA_FRAC,
  parameter int ACC_LEN    = 4
) (
  input logic         clk,
  input logic         reset,
  psum_accum_if.slave bus
);

  localparam int ACC_W = DATA_WIDTH + $clog2(ACC_LEN) + 1;
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  if (ACC_LEN < 1) begin : g_bad_len
    $error("psum_accum: ACC_LEN must be at least 1");
  end
  if (DATA_FRAC >= DATA_WIDTH) begin : g_bad_frac
    $error("psum_accum: DATA_FRAC must be below DATA_WIDTH");
  end

  acc_state_t              state;
  acc_state_t              state_next;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [DATA_WIDTH-1:0] out_data_q;
  logic                    out_sat_q;

  logic                    stall;
  logic                    accept;
  logic                    flush_eff;
  logic                    close;
  logic                    drain;
  logic signed [ACC_W-1:0] sum_next;
  logic signed [ACC_W-1:0] close_val;
  sat_res_t                clamp_res;
  logic                    unused_hi;

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.stall_out = stall;

  // Upper clamp bits are only sign copies once the value is in range.
  assign unused_hi = ^clamp_res.value[63:DATA_WIDTH];

  // Handshake decode, running sum and group-close decision. Flush is masked
  // by stall so a close can never overwrite an unread result.
  always_comb begin
    stall     = bus.out_valid && !bus.out_ready && !reset;
    accept    = bus.in_valid && !stall;
    flush_eff = bus.flush && !stall;
    drain     = bus.out_valid && bus.out_ready;
    sum_next  = ((cnt == '0) ? '0 : acc)
              + {{(ACC_W-DATA_WIDTH){bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
    close     = 1'b0;
    close_val = acc;
    if (accept) begin
      close     = (cnt == CNT_LAST) || flush_eff;
      close_val = sum_next;
    end else if (flush_eff && (cnt != '0)) begin
      close = 1'b1;
    end
    clamp_res = sat_clamp(64'(close_val), DATA_WIDTH);
  end

  // Result-register state: ACCUM while empty, FULL while holding a result.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (close) state_next = FULL;
      FULL:  if (drain && !close) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // State register, group counter, accumulator and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ACCUM;
      cnt        <= '0;
      acc        <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (close) begin
        cnt        <= '0;
        acc        <= '0;
        out_data_q <= clamp_res.value[DATA_WIDTH-1:0];
        out_sat_q  <= clamp_res.ovf;
      end else if (accept) begin
        cnt <= cnt + CNT_W'(1);
        acc <= sum_next;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// Directed testbench for psum_accum: ACC_LEN=4 instance for sums, saturation,
// flush, backpressure and reset, plus an ACC_LEN=1 instance for pass-through.
module tb_psum_accum;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  psum_accum_if #(.DATA_WIDTH(16)) bus ();
  psum_accum_if #(.DATA_WIDTH(16)) bus1 ();

  psum_accum #(.DATA_WIDTH(16), .DATA_FRAC(8), .ACC_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  psum_accum #(.DATA_WIDTH(16), .DATA_FRAC(8), .ACC_LEN(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic feed(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 ||
        bus.out_sat !== 1'b0 || bus.stall_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%h s=%b st=%b expected 0 0000 0 0",
               bus.out_valid, bus.out_data, bus.out_sat, bus.stall_out);
    end
    checks++;
    if (bus1.out_valid !== 1'b0 || bus1.out_data !== 16'h0000 || bus1.stall_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_len1: got v=%b d=%h st=%b expected 0 0000 0",
               bus1.out_valid, bus1.out_data, bus1.stall_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_sum();
    logic [15:0] vec [4];
    vec[0] = 16'h0100; vec[1] = 16'h0080; vec[2] = 16'hFF00; vec[3] = 16'h0040;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      feed(vec[i]);
      checks++;
      if (bus.out_valid !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL basic_valid[%0d]: got %b expected %b", i, bus.out_valid, (i == 3));
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_data !== 16'h00C0 || bus.out_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_data: got %h sat %b expected 00c0 sat 0", bus.out_data, bus.out_sat);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_one_cycle: got valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(16'h7000);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h7FFF || bus.out_sat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_pos: got v=%b d=%h s=%b expected 1 7fff 1",
               bus.out_valid, bus.out_data, bus.out_sat);
    end
    tick();
    for (int i = 0; i < 4; i++) feed(16'h9000);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h8000 || bus.out_sat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_neg: got v=%b d=%h s=%b expected 1 8000 1",
               bus.out_valid, bus.out_data, bus.out_sat);
    end
    tick();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b1;
    feed(16'h0100);
    feed(16'h0100);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0200 || bus.out_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_alone: got v=%b d=%h s=%b expected 1 0200 0",
               bus.out_valid, bus.out_data, bus.out_sat);
    end
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_empty: got valid %b expected 0", bus.out_valid);
    end
    feed(16'h0100);
    feed(16'h0100);
    bus.flush = 1'b1;
    feed(16'h0100);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0300) begin
      errors++;
      $display("[TB] FAIL flush_with_sample: got v=%b d=%h expected 1 0300",
               bus.out_valid, bus.out_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      feed(16'(i));
      checks++;
      if (bus.out_valid !== (i == 4 || i == 8)) begin
        errors++;
        $display("[TB] FAIL b2b_valid[%0d]: got %b expected %b", i, bus.out_valid, (i == 4 || i == 8));
      end
      if (i == 4) begin
        checks++;
        if (bus.out_data !== 16'h000A) begin
          errors++;
          $display("[TB] FAIL b2b_group1: got %h expected 000a", bus.out_data);
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_data !== 16'h001A) begin
      errors++;
      $display("[TB] FAIL b2b_group2: got %h expected 001a", bus.out_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      feed(16'h0010);
      checks++;
      if (i < 3) begin
        if (bus.out_valid !== 1'b0 || bus.stall_out !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bp_fill[%0d]: got v=%b st=%b expected 0 0", i, bus.out_valid, bus.stall_out);
        end
      end else begin
        if (bus.out_valid !== 1'b1 || bus.stall_out !== 1'b1 || bus.out_data !== 16'h0040) begin
          errors++;
          $display("[TB] FAIL bp_hold[%0d]: got v=%b st=%b d=%h expected 1 1 0040",
                   i, bus.out_valid, bus.stall_out, bus.out_data);
        end
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.stall_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: got stall %b expected 0", bus.stall_out);
    end
    for (int i = 0; i < 4; i++) begin
      feed(16'h0010);
      checks++;
      if (bus.out_valid !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL bp_second_valid[%0d]: got %b expected %b", i, bus.out_valid, (i == 3));
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_data !== 16'h0040 || bus.out_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_second_data: got %h sat %b expected 0040 sat 0", bus.out_data, bus.out_sat);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drained: got valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    feed(16'h0100);
    feed(16'h0100);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 ||
        bus.out_sat !== 1'b0 || bus.stall_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got v=%b d=%h s=%b st=%b expected 0 0000 0 0",
               bus.out_valid, bus.out_data, bus.out_sat, bus.stall_out);
    end
    for (int i = 0; i < 4; i++) feed(16'h0001);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL reset_mid_sum: got v=%b d=%h expected 1 0004", bus.out_valid, bus.out_data);
    end
    tick();
  endtask

  task automatic test_acc_len1();
    logic [15:0] vec [2];
    vec[0] = 16'h1234; vec[1] = 16'hEDCC;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = vec[i];
      tick();
      checks++;
      if (bus1.out_valid !== 1'b1 || bus1.out_data !== vec[i] ||
          bus1.out_sat !== 1'b0 || bus1.stall_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL len1_pass[%0d]: got v=%b d=%h s=%b st=%b expected 1 %h 0 0",
                 i, bus1.out_valid, bus1.out_data, bus1.out_sat, bus1.stall_out, vec[i]);
      end
    end
    bus1.in_valid = 1'b0;
    tick();
    checks++;
    if (bus1.out_valid !== 1'b0 || bus1.stall_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL len1_idle: got v=%b st=%b expected 0 0", bus1.out_valid, bus1.stall_out);
    end
  endtask

  // Sequence all scenarios, then report.
  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.flush     = 1'b0;
    bus1.out_ready = 1'b1;
    test_reset();
    test_basic_sum();
    test_saturation();
    test_flush();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_acc_len1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_accum.md
# psum_accum

Partial-sum accumulator that sits directly downstream of the fixed-point saturating adder in the systolic array output path. It consumes the adder's `out`/`done` stream, sums `ACC_LEN` consecutive samples (or fewer on `flush`) in a widened internal accumulator, and saturates the total back to the stream format. The result is presented on a valid/ready port. Backpressure is returned to the adder through its `stall` input.

## Interface
- `DATA_WIDTH`, 16: sample and result width, signed two's complement.
- `DATA_FRAC`, 8: fractional bits. Input and output share the same Q format, so no realignment is done.
- `ACC_LEN`, 4: samples per result. Legal values are 1 or more.
- `clk` input, 1 bit: the single clock. All logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in_valid` input, 1 bit: sample present. Driven by the adder's `done`.
- `in_data` input, `DATA_WIDTH` bits: the sample. Driven by the adder's `out`.
- `flush` input, 1 bit: close the current group early.
- `stall_out` output, 1 bit: drives the adder's `stall`. While it is high, the upstream stage holds `in_valid`/`in_data`.
- `out_valid` output, 1 bit: result register full.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_data` output, `DATA_WIDTH` bits: saturated result.
- `out_sat` output, 1 bit: `out_data` was clamped. Qualified by `out_valid`.

## Operation
- Internal accumulator width is `ACC_W = DATA_WIDTH + $clog2(ACC_LEN) + 1`. No internal overflow is possible, so saturation happens only at output.
- Accept condition: `accept = in_valid && !stall_out`. When `stall_out` is high, `in_valid` is ignored.
- `cnt` counts from 0 to `ACC_LEN-1` and tracks samples in the current group.
- On `accept`:
  - next sum = (`cnt==0` ? 0 : `acc`) + sign-extend(`in_data`).
  - If `cnt==ACC_LEN-1`, the group closes. Otherwise `acc` takes the next sum and `cnt` increments.
- Closing with `flush`:
  - `flush` with `accept` in the same cycle: the sample is included, then the group closes.
  - `flush` without `accept` and with `cnt>0`: the group closes with the current `acc`.
  - `flush` with `cnt==0` and no `accept`: no effect, no output.
- On close:
  - `out_data` takes the clamp of the sum to [`-2^(DATA_WIDTH-1)`, `2^(DATA_WIDTH-1)-1`].
  - `out_sat` is 1 if a clamp occurred.
  - `out_valid` goes to 1.
  - `cnt` and `acc` go to 0.
- Output register:
  - Cleared (`out_valid` goes to 0) on `out_valid && out_ready` when no close happens that cycle.
  - Close and drain in the same cycle: the register reloads and `out_valid` stays 1.
- Backpressure: `stall_out = out_valid && !out_ready && !reset`. This is combinational from `out_ready`.
  - `flush` is also ignored while `stall_out` is high, so a close can never overwrite an unread result.
- Two-state FSM:
  - `ACCUM` (`out_valid`=0) moves to `FULL` on close.
  - `FULL` moves to `ACCUM` on drain without close, and stays in `FULL` on drain with close or when not drained.
- `ACC_LEN==1`: every accepted sample closes immediately, so the block acts as a one-entry skid register.

## Timing
- Reset values:
  - `out_valid` 0, `out_data` 0, `out_sat` 0.
  - `stall_out` 0.
  - `cnt` 0, `acc` 0.
- Reset mid-group discards the partial sum and any unread result.
- Latency: the last accepted sample at edge N gives `out_valid`=1 after edge N, visible in cycle N+1.
- Throughput is one sample per cycle with a continuous drain (`out_ready`=1). There are no bubbles between groups.
- `stall_out` rises in the same cycle that `out_valid`=1 and `out_ready`=0. The adder then freezes its registers at the next edge.

## Structure
- Shared package `systolic_pkg`:
  - default `DATA_WIDTH`/`DATA_FRAC` constants,
  - a `sat_clamp` function (wide signed value to `DATA_WIDTH` bits plus an overflow flag), also used by other array stages,
  - the `ACCUM`/`FULL` state enum.
- No sub-module. The counter, accumulator, FSM and output register are a single module.

## Test plan
All values are Q8.8 with `ACC_LEN=4` unless stated.
- **Basic sum:** inputs 0x0100, 0x0080, 0xFF00, 0x0040 on consecutive cycles with `out_ready`=1. Expect `out_data`=0x00C0, `out_sat`=0, `out_valid` high for exactly one cycle, one cycle after the 4th sample.
- **Saturation:**
  - Four inputs of 0x7000 give `out_data`=0x7FFF, `out_sat`=1.
  - Four inputs of 0x9000 give 0x8000, `out_sat`=1.
- **Flush:**
  - 0x0100, 0x0100, then `flush` alone gives 0x0200.
  - `flush` with `cnt==0` gives no `out_valid`.
  - `flush` together with a 3rd sample of 0x0100 gives 0x0300.
- **Backpressure:** hold `out_ready`=0 and stream 8 samples of 0x0010.
  - Expect 0x0040 to be held and `stall_out`=1.
  - The 5th and later samples are not consumed while `stall_out` is high.
  - Raise `out_ready` and expect a second result of 0x0040 with no sample lost or duplicated.
- **Reset mid-operation:** after 2 samples, assert `reset` for 1 cycle, then feed 4 samples of 0x0001.
  - Expect 0x0004.
  - All outputs are 0 in the cycle after reset.
- **ACC_LEN=1:** stream 0x1234 and 0xEDCC with `out_ready`=1. Expect pass-through at 1-cycle latency and `stall_out` constantly 0.
